// File: rtl/conv_seq_pkg.sv
// Shared widths, state encoding and constants for the convolution sequencer.
// The address widths match the input, filter and output RAM depths.
package conv_seq_pkg;

  localparam int DATA_W = 16;
  localparam int DIM_AW = 9;
  localparam int BVM_AW = 10;
  localparam int DOM_AW = 3;

  localparam logic [DATA_W-1:0] TIMEOUT_FILL = 16'h8000;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RES,
    WRITE,
    DONE
  } seq_state_t;

endpackage

// File: rtl/conv_sequencer_if.sv
// RAM, MAC and control signals of the convolution sequencer.
// The master modport is the sequencer side; the slave modport is the environment.
interface conv_sequencer_if;
  import conv_seq_pkg::*;

  logic              xxx__dut__go;
  logic              dut__xxx__finish;
  logic              dut__xxx__error;

  logic [DIM_AW-1:0] dut__dim__address;
  logic              dut__dim__enable;
  logic              dut__dim__write;
  logic [DATA_W-1:0] dut__dim__data;
  logic [DATA_W-1:0] dim__dut__data;

  logic [BVM_AW-1:0] dut__bvm__address;
  logic              dut__bvm__enable;
  logic              dut__bvm__write;
  logic [DATA_W-1:0] dut__bvm__data;
  logic [DATA_W-1:0] bvm__dut__data;

  logic [DOM_AW-1:0] dut__dom__address;
  logic [DATA_W-1:0] dut__dom__data;
  logic              dut__dom__enable;
  logic              dut__dom__write;

  logic              seq__mac__valid;
  logic              seq__mac__first;
  logic              seq__mac__last;
  logic [DATA_W-1:0] seq__mac__z;
  logic [DATA_W-1:0] seq__mac__m;
  logic [DATA_W-1:0] mac__seq__result;
  logic              mac__seq__result_valid;

  modport master (
    input  xxx__dut__go, dim__dut__data, bvm__dut__data,
           mac__seq__result, mac__seq__result_valid,
    output dut__xxx__finish, dut__xxx__error,
           dut__dim__address, dut__dim__enable, dut__dim__write, dut__dim__data,
           dut__bvm__address, dut__bvm__enable, dut__bvm__write, dut__bvm__data,
           dut__dom__address, dut__dom__data, dut__dom__enable, dut__dom__write,
           seq__mac__valid, seq__mac__first, seq__mac__last,
           seq__mac__z, seq__mac__m
  );

  modport slave (
    output xxx__dut__go, dim__dut__data, bvm__dut__data,
           mac__seq__result, mac__seq__result_valid,
    input  dut__xxx__finish, dut__xxx__error,
           dut__dim__address, dut__dim__enable, dut__dim__write, dut__dim__data,
           dut__bvm__address, dut__bvm__enable, dut__bvm__write, dut__bvm__data,
           dut__dom__address, dut__dom__data, dut__dom__enable, dut__dom__write,
           seq__mac__valid, seq__mac__first, seq__mac__last,
           seq__mac__z, seq__mac__m
  );

endinterface

// File: rtl/conv_seq_addr_gen.sv
// Element (e) and output (k) counters with base+offset RAM address arithmetic.
// Addresses are formed at full integer width and truncated to the RAM width.
module conv_seq_addr_gen
  import conv_seq_pkg::*;
#(
  parameter int VEC_LEN     = 64,
  parameter int N_OUT       = 8,
  parameter int INPUT_BASE  = 0,
  parameter int FILTER_BASE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              e_step,
  input  logic              k_step,
  output logic              e_first,
  output logic              e_last,
  output logic              k_last,
  output logic [DOM_AW-1:0] k_addr,
  output logic [DIM_AW-1:0] dim_addr,
  output logic [BVM_AW-1:0] bvm_addr
);

  localparam int EW = 6;

  logic [EW-1:0]     e_p0;
  logic [DOM_AW-1:0] k_p0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_p0 <= '0;
      k_p0 <= '0;
    end else if (clr) begin
      e_p0 <= '0;
      k_p0 <= '0;
    end else begin
      if (e_step) e_p0 <= e_last ? '0 : e_p0 + EW'(1);
      if (k_step) k_p0 <= k_p0 + DOM_AW'(1);
    end
  end

  assign e_first  = (e_p0 == '0);
  assign e_last   = (e_p0 == EW'(VEC_LEN - 1));
  assign k_last   = (k_p0 == DOM_AW'(N_OUT - 1));
  assign k_addr   = k_p0;
  assign dim_addr = DIM_AW'(INPUT_BASE + int'(e_p0));
  assign bvm_addr = BVM_AW'(FILTER_BASE + int'(k_p0) * VEC_LEN + int'(e_p0));

endmodule

// File: rtl/conv_sequencer.sv
// Convolution controller: streams input/filter RAM words to the MAC, one dot
// product per output, and writes each MAC result (or a timeout fill) to output RAM.
module conv_sequencer
  import conv_seq_pkg::*;
#(
  parameter int VEC_LEN        = 64,
  parameter int N_OUT          = 8,
  parameter int INPUT_BASE     = 0,
  parameter int FILTER_BASE    = 0,
  parameter int RESULT_TIMEOUT = 255
) (
  input logic              clk,
  input logic              reset,
  conv_sequencer_if.master bus
);

  seq_state_t        state_p0, state_nxt;
  logic              clr, e_step, k_step;
  logic              e_first, e_last, k_last;
  logic [DOM_AW-1:0] k_addr;
  logic [DIM_AW-1:0] dim_addr;
  logic [BVM_AW-1:0] bvm_addr;
  logic [15:0]       tmo_p0;
  logic              tmo_hit, issuing;
  logic              vld_p1, first_p1, last_p1;
  logic              error_p0;
  logic [DATA_W-1:0] res_p0;

  conv_seq_addr_gen #(
    .VEC_LEN    (VEC_LEN),
    .N_OUT      (N_OUT),
    .INPUT_BASE (INPUT_BASE),
    .FILTER_BASE(FILTER_BASE)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .e_step  (e_step),
    .k_step  (k_step),
    .e_first (e_first),
    .e_last  (e_last),
    .k_last  (k_last),
    .k_addr  (k_addr),
    .dim_addr(dim_addr),
    .bvm_addr(bvm_addr)
  );

  assign issuing = (state_p0 == ISSUE);
  assign tmo_hit = (state_p0 == WAIT_RES) && (tmo_p0 == 16'(RESULT_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_p0 <= IDLE;
    else        state_p0 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p0;
    clr       = 1'b0;
    e_step    = 1'b0;
    k_step    = 1'b0;
    case (state_p0)
      IDLE: begin
        if (bus.xxx__dut__go) begin
          state_nxt = ISSUE;
          clr       = 1'b1;
        end
      end
      ISSUE: begin
        e_step = 1'b1;
        if (e_last) state_nxt = WAIT_RES;
      end
      WAIT_RES: begin
        if (bus.mac__seq__result_valid || tmo_hit) state_nxt = WRITE;
      end
      WRITE: begin
        if (k_last) state_nxt = DONE;
        else begin
          k_step    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p0 -> p1: strobes lag the issued address by the RAM read latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_p0   <= '0;
      error_p0 <= 1'b0;
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
    end else begin
      tmo_p0 <= (state_p0 == WAIT_RES) ? tmo_p0 + 16'd1 : '0;
      if (clr)
        error_p0 <= 1'b0;
      else if (tmo_hit && !bus.mac__seq__result_valid)
        error_p0 <= 1'b1;
      vld_p1   <= issuing;
      first_p1 <= issuing && e_first;
      last_p1  <= issuing && e_last;
    end
  end

  // A real result in the timeout cycle takes priority over the fill value
  always_ff @(posedge clk) begin
    if (state_p0 == WAIT_RES) begin
      if (bus.mac__seq__result_valid) res_p0 <= bus.mac__seq__result;
      else if (tmo_hit)               res_p0 <= TIMEOUT_FILL;
    end
  end

  assign bus.dut__dim__enable  = issuing;
  assign bus.dut__dim__address = issuing ? dim_addr : '0;
  assign bus.dut__dim__write   = 1'b0;
  assign bus.dut__dim__data    = '0;
  assign bus.dut__bvm__enable  = issuing;
  assign bus.dut__bvm__address = issuing ? bvm_addr : '0;
  assign bus.dut__bvm__write   = 1'b0;
  assign bus.dut__bvm__data    = '0;

  assign bus.dut__dom__enable  = (state_p0 == WRITE);
  assign bus.dut__dom__write   = (state_p0 == WRITE);
  assign bus.dut__dom__address = (state_p0 == WRITE) ? k_addr : '0;
  assign bus.dut__dom__data    = (state_p0 == WRITE) ? res_p0 : '0;

  assign bus.seq__mac__valid   = vld_p1;
  assign bus.seq__mac__first   = first_p1;
  assign bus.seq__mac__last    = last_p1;
  assign bus.seq__mac__z       = vld_p1 ? bus.dim__dut__data : '0;
  assign bus.seq__mac__m       = vld_p1 ? bus.bvm__dut__data : '0;

  assign bus.dut__xxx__finish  = (state_p0 == DONE);
  assign bus.dut__xxx__error   = error_p0;

endmodule

// File: doc/conv_sequencer.md
Name: conv_sequencer

Overview:
- Controller for the convolution datapath. On `go` it streams input-RAM and filter-RAM words into the external MAC unit, one dot product per output.
- It collects each MAC result and writes it to output RAM, then pulses `finish`.
- It owns all dim/bvm/dom RAM ports, so the top level instantiates it between the RAMs and the MAC.

Parameters:
- VEC_LEN, 64, elements per dot product (1..64).
- N_OUT, 8, outputs per run (1..8). Each output k uses filter words FILTER_BASE+k*VEC_LEN+e.
- INPUT_BASE, 0, first input-RAM word (9 bit).
- FILTER_BASE, 0, first filter-RAM word (10 bit).
- RESULT_TIMEOUT, 255, maximum cycles waiting for a MAC result.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- xxx__dut__go  in  1  start request.
- dut__xxx__finish  out  1  one-cycle done pulse.
- dut__xxx__error  out  1  sticky flag: a timeout occurred in the current/last run.
- dut__dim__address  out  9  input-RAM address.
- dut__dim__enable  out  1  input-RAM enable.
- dut__dim__write  out  1  input-RAM write enable; constant 0.
- dut__dim__data  out  16  input-RAM write data; constant 0.
- dim__dut__data  in  16  input-RAM read data; 1-cycle synchronous latency.
- dut__bvm__address  out  10  filter-RAM address.
- dut__bvm__enable  out  1  filter-RAM enable.
- dut__bvm__write  out  1  filter-RAM write enable; constant 0.
- dut__bvm__data  out  16  filter-RAM write data; constant 0.
- bvm__dut__data  in  16  filter-RAM read data; 1-cycle latency.
- dut__dom__address  out  3  output-RAM address.
- dut__dom__data  out  16  output-RAM write data.
- dut__dom__enable  out  1  output-RAM enable.
- dut__dom__write  out  1  output-RAM write enable.
- seq__mac__valid  out  1  z/m element pair valid this cycle.
- seq__mac__first  out  1  qualifies the first element of a vector.
- seq__mac__last  out  1  qualifies the last element of a vector.
- seq__mac__z  out  16  element from dim__dut__data, combinational pass-through.
- seq__mac__m  out  16  element from bvm__dut__data, combinational pass-through.
- mac__seq__result  in  16  dot-product result.
- mac__seq__result_valid  in  1  result strobe.

Behaviour:
- Reset: all outputs 0, state IDLE, counters k=0, e=0, timeout count 0.
- FSM states: IDLE, ISSUE, WAIT_RES, WRITE, DONE.
- IDLE:
  - go=1 at a rising edge -> ISSUE, clear error, k=0, e=0.
  - go is level-sampled; go asserted in any other state is ignored.
- ISSUE (VEC_LEN cycles per output):
  - dim and bvm enable=1.
  - dim address = INPUT_BASE+e; bvm address = FILTER_BASE+k*VEC_LEN+e, computed at full width then truncated.
  - e increments each cycle.
  - Registered strobes one cycle later, aligned with RAM data:
    - seq__mac__valid = 1 for every issued element.
    - first when the issued e was 0.
    - last when the issued e was VEC_LEN-1 (first and last both 1 when VEC_LEN=1).
  - After issuing e=VEC_LEN-1 -> WAIT_RES, e=0.
- WAIT_RES:
  - RAM enables 0. The first WAIT_RES cycle carries the last valid element.
  - Timeout counter increments each cycle from 0.
  - result_valid=1 -> latch result -> WRITE.
  - Otherwise, when the counter reaches RESULT_TIMEOUT-1: latch 16'h8000, set error -> WRITE.
  - result_valid in the same cycle as the timeout hit: the result wins, error not set.
- WRITE (1 cycle):
  - dom enable=write=1, address=k, data=latched value.
  - If k==N_OUT-1 -> DONE; else k++ -> ISSUE.
- DONE: finish=1 for exactly one cycle -> IDLE.
- result_valid outside WAIT_RES is ignored, including a strobe in the first WAIT_RES cycle's predecessor.
- Timing:
  - go sampled at edge T: first address at cycle T+1, first seq__mac__valid at T+2.
  - Per output: VEC_LEN + W + 1 cycles, where W = WAIT_RES cycles (≥1).
  - Example: VEC_LEN=64, N_OUT=8, MAC returns result in the 3rd WAIT_RES cycle: finish at cycle T + 8*(64+3+1) + 1.
- Reset asserted mid-run: immediate return to IDLE; all enables/strobes drop asynchronously; no finish pulse; no dom write.
- error stays set until the next accepted go.

Decomposition:
- Package conv_seq_pkg:
  - state encoding enum.
  - address widths (9/10/3), data width 16.
  - timeout fill value 16'h8000.
- Sub-module conv_seq_addr_gen:
  - holds k/e counters and base+offset address arithmetic.
  - outputs first/last/done-vector flags.
  - the FSM stays in conv_sequencer.

Test Plan:
- Default params; MAC model returns the sum of z*m 2 cycles after last. Required:
  - 8 dom writes, addresses 0..7, correct values.
  - bvm addresses 0..511 in order; dim addresses 0..63 repeated 8 times.
  - one finish pulse at T+545.
  - error stays 0.
- MAC model withholds the result for output 3. Required:
  - dom[3]=16'h8000 written RESULT_TIMEOUT cycles after WAIT_RES entry.
  - error=1; the run continues, and outputs 4..7 are correct.
- go pulsed again during ISSUE of output 2. Required: ignored; exactly 8 writes and 1 finish.
- reset low during WAIT_RES of output 5. Required:
  - all outputs 0 within the same cycle; no further dom writes or finish.
  - a following go restarts from k=0.
- VEC_LEN=1, N_OUT=1, MAC result coincident with the timeout cycle. Required:
  - first=last=1 on the single valid.
  - result written to dom[0], error=0.
- Result strobe during ISSUE. Required: ignored; the written value comes from the in-window strobe.
